// File: rtl/eof_snapshot_ctrl.sv
// eof_snapshot_ctrl
//   Per-source EOF event counters with a software-triggered snapshot of one
//   counter into a shared readback register.
//
//   Software flips ctrl_word[31] to request a snapshot of the source selected
//   by ctrl_word[3:0]. Completion is seen by polling snap_seq in snap_status.
//
//   Build option: define EOF_SNAPSHOT_CLEAR_EN to zero the selected counter
//   as it is copied (clear-on-read). Default build leaves counters untouched.
//
// Ports
//   OPB_Clk      in   1         clock, all state on rising edge
//   OPB_Rst      in   1         synchronous active-high reset
//   eof_in       in   NUM_SRC   per-source EOF strobe, one count per high cycle
//   ctrl_word    in   32        bit31 request toggle, bits[3:0] source index
//   snap_data    out  CNT_W     frozen counter value
//   snap_status  out  32        {16'b0, snap_seq, 2'b0, err, busy, idx}
//   busy         out  1         snapshot in progress
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for ctrl_word[31] to differ from tog_q
// LATCH | copy selected counter (or all ones if index out of range)
// DONE  | bump snap_seq, return to IDLE

module eof_snapshot_ctrl #(
    parameter int NUM_SRC = 4,
    parameter int CNT_W   = 32
) (
    input  logic               OPB_Clk,
    input  logic               OPB_Rst,
    input  logic [NUM_SRC-1:0] eof_in,
    input  logic [31:0]        ctrl_word,
    output logic [CNT_W-1:0]   snap_data,
    output logic [31:0]        snap_status,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic             tog_q;
    logic [3:0]       idx;
    logic             err;
    logic [7:0]       snap_seq;
    logic [CNT_W-1:0] cnt [NUM_SRC];
    logic [CNT_W-1:0] sel_cnt;
    logic             idx_bad;
    logic             clr_sel;
    logic             unused_ctrl;

    assign unused_ctrl = ^ctrl_word[30:4];

    // Mux by compare so an out-of-range idx never indexes past the array.
    always_comb begin
        sel_cnt = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (idx == 4'(i)) begin
                sel_cnt = cnt[i];
            end
        end
    end

    assign idx_bad = ({1'b0, idx} >= 5'(NUM_SRC));

`ifdef EOF_SNAPSHOT_CLEAR_EN
    assign clr_sel = (state == LATCH) && !idx_bad;
`else
    assign clr_sel = 1'b0;
`endif

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt[i] <= '0;
            end
            // Track the live toggle so leaving reset never looks like a request.
            tog_q     <= ctrl_word[31];
            state     <= IDLE;
            busy      <= 1'b0;
            idx       <= '0;
            err       <= 1'b0;
            snap_data <= '0;
            snap_seq  <= '0;
        end else begin
            tog_q <= ctrl_word[31];

            // Clear-on-read still counts a same-cycle pulse, leaving 1.
            for (int i = 0; i < NUM_SRC; i++) begin
                if (clr_sel && (idx == 4'(i))) begin
                    cnt[i] <= CNT_W'(eof_in[i]);
                end else if (eof_in[i]) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (ctrl_word[31] != tog_q) begin
                        idx   <= ctrl_word[3:0];
                        state <= LATCH;
                        busy  <= 1'b1;
                    end
                end
                LATCH: begin
                    if (idx_bad) begin
                        err       <= 1'b1;
                        snap_data <= '1;
                    end else begin
                        err       <= 1'b0;
                        snap_data <= sel_cnt;
                    end
                    state <= DONE;
                end
                DONE: begin
                    snap_seq <= snap_seq + 8'd1;
                    state    <= IDLE;
                    busy     <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign snap_status = {16'b0, snap_seq, 2'b0, err, busy, idx};

endmodule

// File: doc/eof_snapshot_ctrl.md
EOF_SNAPSHOT_CTRL -- requirements
Module: eof_snapshot_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 4 (range 1..16): number of EOF event sources sharing one readback register.
REQ-002 The block SHALL have parameter CNT_W, default 32: width of each EOF counter and of snap_data.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, named OPB_Clk and OPB_Rst.
REQ-004 OPB_Clk  input  1  single clock; all state changes on its rising edge.
REQ-005 OPB_Rst  input  1  synchronous active-high reset.
REQ-006 eof_in  input  NUM_SRC  per-source EOF strobe; one count per high cycle.
REQ-007 ctrl_word  input  32  software control word: bit31 = request toggle, bits[3:0] = source index.
REQ-008 snap_data  output  CNT_W  frozen counter value, driven to the 32-bit simulink2ppc readback register.
REQ-009 snap_status  output  32  {16'b0, snap_seq[7:0], 2'b0, err, busy, idx[3:0]}.
REQ-010 busy  output  1  high while a snapshot is in progress.

Function
REQ-011 The block SHALL keep one CNT_W counter per source, incremented by 1 in every cycle its eof_in bit is high.
REQ-012 Counters SHALL wrap modulo 2^CNT_W without saturation or error.
REQ-013 The block SHALL register ctrl_word[31] into tog_q every cycle; a request SHALL be ctrl_word[31] != tog_q while in IDLE.
REQ-014 The FSM SHALL have states IDLE, LATCH and DONE; busy SHALL be high in LATCH and DONE only.
REQ-015 IDLE -> LATCH on request; ctrl_word[3:0] SHALL be captured into idx on that same edge.
REQ-016 LATCH -> DONE unconditionally; in LATCH the selected counter SHALL be copied to snap_data.
REQ-017 The copied value SHALL be the counter value before any same-cycle eof_in increment.
REQ-018 If idx >= NUM_SRC, LATCH SHALL set err=1 and load snap_data with all ones; otherwise it SHALL clear err.
REQ-019 DONE -> IDLE unconditionally, and snap_seq SHALL increment by 1 (mod 256) on that transition.
REQ-020 Latency: request visible at edge 0 -> busy=1 after edge 1 -> snap_data valid after edge 2 -> snap_seq updated and busy=0 after edge 3.
REQ-021 Toggles during LATCH or DONE SHALL be dropped (tog_q still tracks); software detects completion by polling snap_seq.
REQ-022 snap_data and snap_status SHALL hold their values between snapshots.
REQ-023 Counting SHALL continue in every FSM state, including during a snapshot.

Reset
REQ-024 Reset SHALL set all counters, snap_data, snap_seq, idx and err to 0, and force the FSM to IDLE with busy=0.
REQ-025 During reset, tog_q SHALL load ctrl_word[31] so that no spurious request occurs after reset.
REQ-026 Reset asserted in LATCH or DONE SHALL abort the snapshot without incrementing snap_seq.
REQ-027 eof_in pulses coincident with reset SHALL NOT be counted.

Configuration
REQ-028 Macro EOF_SNAPSHOT_CLEAR_EN SHALL select clear-on-snapshot behaviour.
REQ-029 With EOF_SNAPSHOT_CLEAR_EN defined, LATCH SHALL zero the selected counter while copying it; a same-cycle eof_in on that source SHALL leave the counter at 1.
REQ-030 Without EOF_SNAPSHOT_CLEAR_EN, snapshots SHALL NOT modify any counter.
REQ-031 An err snapshot (idx >= NUM_SRC) SHALL NOT clear any counter in either build.

Verification
REQ-032 Scenario: 5 pulses on eof_in[2], then toggle bit31 with index 2 -> snap_data=5, err=0, snap_seq=1, and busy high for exactly 2 cycles.
REQ-033 Scenario: preload counter 0 to 0xFFFFFFFF, pulse eof_in[0] once, snapshot index 0 -> snap_data=0.
REQ-034 Scenario: snapshot index 7 with NUM_SRC=4 -> snap_data=0xFFFFFFFF, err=1, and the counters are unchanged.
REQ-035 Scenario: EOF_SNAPSHOT_CLEAR_EN defined, counter 1 = 9, eof_in[1] high in LATCH -> snap_data=9, counter 1 = 1; without the macro -> snap_data=9, counter 1 = 10.
REQ-036 Scenario: second toggle one cycle after the first -> only one snapshot occurs and snap_seq increments by exactly 1.
REQ-037 Scenario: OPB_Rst asserted in DONE -> busy=0, snap_seq=0, all counters 0, and no request fires after reset release with ctrl_word unchanged.
